sfp_acc_act: RTL and testbench

//  Special-function stage downstream of the psum memory (pmem) in core.
//  Per column: accumulates the 9 kij partial sums read from pmem for one output pixel (onij),

---
 rtl/sfp_acc_act_if.sv | 30 +++
 rtl/sfp_acc_act.sv | 146 ++++++++++++++
 tb/tb_sfp_acc_act.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/sfp_acc_act_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : sfp_acc_act_if                                                |
// | Description: Bundle of accumulate strobe, activation select, psum data and |
// |              activated result/status for the special-function stage.      |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
interface sfp_acc_act_if #(
  parameter int COL     = 8,
  parameter int PSUM_BW = 16
);
  logic                     acc;
  logic [2:0]               act;
  logic [COL*PSUM_BW-1:0]   data_in;
  logic [COL*PSUM_BW-1:0]   sfp_out;
  logic                     out_valid;
  logic [3:0]               acc_cnt;
  logic                     cnt_err;

  modport master (
    output acc, act, data_in,
    input  sfp_out, out_valid, acc_cnt, cnt_err
  );

  modport slave (
    input  acc, act, data_in,
    output sfp_out, out_valid, acc_cnt, cnt_err
  );
endinterface
`default_nettype wire

// File: rtl/sfp_acc_act.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : sfp_acc_act                                                   |
// | Description: Per-column accumulation of kij partial sums followed by a     |
// |              selectable activation. SFP_SAT_EN selects saturating adds.    |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module sfp_acc_act #(
  parameter int COL     = 8,
  parameter int PSUM_BW = 16,
  parameter int LEN_KIJ = 9
) (
  input  wire logic      clk,
  input  wire logic      reset,
  sfp_acc_act_if.slave   bus
);

  localparam logic [0:0] c_IDLE  = 1'b0;
  localparam logic [0:0] c_ACCUM = 1'b1;
  localparam logic [3:0] c_LEN   = 4'(LEN_KIJ);

  logic [0:0]                r_state;
  logic [0:0]                w_next_state;
  logic                      w_load;
  logic                      w_add;
  logic                      w_close;
  logic [2:0]                r_act;
  logic [3:0]                r_acc_cnt;
  logic                      r_out_valid;
  logic                      r_cnt_err;
  logic signed [PSUM_BW-1:0] r_accum [COL];
  logic [PSUM_BW-1:0]        r_out   [COL];
  logic [COL*PSUM_BW-1:0]    w_sfp_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:  if (bus.acc)  w_next_state = c_ACCUM;
      c_ACCUM: if (!bus.acc) w_next_state = c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  always_comb begin
    w_load  = 1'b0;
    w_add   = 1'b0;
    w_close = 1'b0;
    case (r_state)
      c_IDLE:  w_load  = bus.acc;
      c_ACCUM: begin
        w_add   = bus.acc;
        w_close = !bus.acc;
      end
      default: ;
    endcase
  end

  // act is captured only on the first beat so mid-pixel changes are ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_act       <= 3'd0;
      r_acc_cnt   <= 4'd0;
      r_out_valid <= 1'b0;
      r_cnt_err   <= 1'b0;
    end else begin
      r_out_valid <= w_close;
      if (w_load) begin
        r_act     <= bus.act;
        r_acc_cnt <= 4'd1;
      end else if (w_add && (r_acc_cnt != 4'hF)) begin
        r_acc_cnt <= r_acc_cnt + 4'd1;
      end
      if (w_close && (r_acc_cnt != c_LEN)) begin
        r_cnt_err <= 1'b1;
      end
    end
  end

  for (genvar c = 0; c < COL; c++) begin : g_lane
    logic [PSUM_BW-1:0] w_din;
    logic [PSUM_BW:0]   w_sum;
    logic [PSUM_BW-1:0] w_add_res;
    logic [PSUM_BW-1:0] w_act_res;

    assign w_din = bus.data_in[c*PSUM_BW +: PSUM_BW];
    assign w_sum = {r_accum[c][PSUM_BW-1], r_accum[c]} + {w_din[PSUM_BW-1], w_din};

    // Overflow shows as disagreement between the two top bits of the extended sum
    always_comb begin
      w_add_res = w_sum[PSUM_BW-1:0];
`ifdef SFP_SAT_EN
      if (w_sum[PSUM_BW] != w_sum[PSUM_BW-1]) begin
        w_add_res = w_sum[PSUM_BW] ? {1'b1, {(PSUM_BW-1){1'b0}}}
                                   : {1'b0, {(PSUM_BW-1){1'b1}}};
      end
`endif
    end

    always_comb begin
      w_act_res = r_accum[c];
      case (r_act)
        3'd0:    if (r_accum[c][PSUM_BW-1]) w_act_res = '0;
        3'd1:    if (r_accum[c][PSUM_BW-1]) w_act_res = r_accum[c] >>> 3;
        default: ;
      endcase
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_accum[c] <= '0;
        r_out[c]   <= '0;
      end else begin
        if (w_load) begin
          r_accum[c] <= w_din;
        end else if (w_add) begin
          r_accum[c] <= w_add_res;
        end
        if (w_close) begin
          r_out[c] <= w_act_res;
        end
      end
    end
  end

  always_comb begin
    w_sfp_out = '0;
    for (int c = 0; c < COL; c++) begin
      w_sfp_out[c*PSUM_BW +: PSUM_BW] = r_out[c];
    end
  end

  assign bus.sfp_out   = w_sfp_out;
  assign bus.out_valid = r_out_valid;
  assign bus.acc_cnt   = r_acc_cnt;
  assign bus.cnt_err   = r_cnt_err;

endmodule
`default_nettype wire

// File: tb/tb_sfp_acc_act.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_sfp_acc_act                                                |
// | Description: Directed scoreboard bench for sfp_acc_act (both SFP_SAT_EN    |
// |              builds).                                                      |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module tb_sfp_acc_act;

  localparam int COL     = 8;
  localparam int PSUM_BW = 16;
  localparam int W       = COL * PSUM_BW;

  typedef struct {
    logic [W-1:0] data;
    logic [3:0]   cnt;
    logic         err;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t sb_q[$];

  sfp_acc_act_if #(.COL(COL), .PSUM_BW(PSUM_BW)) bus ();

  sfp_acc_act #(.COL(COL), .PSUM_BW(PSUM_BW), .LEN_KIJ(9)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  // Monitor: every out_valid pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!reset && bus.out_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_out_valid", W'(1), W'(0));
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("lane0",   W'(bus.sfp_out[15:0]),  W'(e.data[15:0]));
        chk("lane1",   W'(bus.sfp_out[31:16]), W'(e.data[31:16]));
        chk("sfp_out", bus.sfp_out, e.data);
        chk("acc_cnt", W'(bus.acc_cnt), W'(e.cnt));
        chk("cnt_err", W'(bus.cnt_err), W'(e.err));
      end
    end
  end

  // n beats, then one acc=0 closing cycle; act changes after the first beat
  task automatic pixel(input int n, input logic [15:0] d0, input logic [15:0] d1,
                       input logic [2:0] a, input logic [15:0] e0, input logic [15:0] e1,
                       input logic [3:0] ecnt, input logic eerr);
    exp_t e;
    e.data = '0;
    e.data[15:0]  = e0;
    e.data[31:16] = e1;
    e.cnt  = ecnt;
    e.err  = eerr;
    sb_q.push_back(e);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.acc     = 1'b1;
      bus.act     = (i == 0) ? a : 3'(a + 3'd1);
      bus.data_in = '0;
      bus.data_in[15:0]  = d0;
      bus.data_in[31:16] = d1;
    end
    @(posedge clk); #1;
    bus.acc     = 1'b0;
    bus.act     = 3'd0;
    bus.data_in = {(W/16){16'hA5A5}};
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bus.acc = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    bus.acc     = 1'b0;
    bus.act     = 3'd0;
    bus.data_in = '0;
    @(negedge clk);
    chk("rst_sfp_out",   bus.sfp_out, W'(0));
    chk("rst_out_valid", W'(bus.out_valid), W'(0));
    chk("rst_acc_cnt",   W'(bus.acc_cnt), W'(0));
    chk("rst_cnt_err",   W'(bus.cnt_err), W'(0));
    @(posedge clk); #1 reset = 1'b0;

    // T1 ReLU, T2 leaky ReLU
    pixel(9, 16'd5,      16'hFFFD, 3'd0, 16'd45,   16'd0,    4'd9, 1'b0);
    pixel(9, 16'hFFF8,   16'hFFFF, 3'd1, 16'hFFF7, 16'hFFFE, 4'd9, 1'b0);
    // T3 back-to-back pixels, identity
    pixel(9, 16'd1,      16'hFFFF, 3'd2, 16'd9,    16'hFFF7, 4'd9, 1'b0);
    pixel(9, 16'd2,      16'd3,    3'd2, 16'd18,   16'd27,   4'd9, 1'b0);
    // T4 overflow, reserved act code behaves as identity
`ifdef SFP_SAT_EN
    pixel(9, 16'd16000,  16'hC180, 3'd5, 16'd32767, 16'h8000, 4'd9, 1'b0);
`else
    pixel(9, 16'd16000,  16'hC180, 3'd5, 16'd12928, 16'hCD80, 4'd9, 1'b0);
`endif

    // T5 reset after four beats
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus.acc = 1'b1; bus.act = 3'd0; bus.data_in = '0; bus.data_in[15:0] = 16'd7;
    end
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    chk("t5_sfp_out", bus.sfp_out, W'(0));
    chk("t5_acc_cnt", W'(bus.acc_cnt), W'(0));
    chk("t5_cnt_err", W'(bus.cnt_err), W'(0));
    pixel(9, 16'd7,      16'd2,    3'd0, 16'd63,   16'd18,   4'd9, 1'b0);

    // T6 short pixel makes cnt_err sticky; also one-beat pulse and count saturation
    pixel(8, 16'd1,      16'd0,    3'd2, 16'd8,    16'd0,    4'd8, 1'b1);
    pixel(9, 16'd4,      16'd0,    3'd2, 16'd36,   16'd0,    4'd9, 1'b1);
    pixel(1, 16'd100,    16'hFF9C, 3'd0, 16'd100,  16'd0,    4'd1, 1'b1);
    pixel(17, 16'd1,     16'd0,    3'd2, 16'd17,   16'd0,    4'd15, 1'b1);

    begin
      int budget;
      budget = 0;
      while (sb_q.size() != 0 && budget < 20) begin
        @(negedge clk);
        budget++;
      end
      chk("scoreboard_drained", W'(sb_q.size()), W'(0));
    end
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    chk("final_cnt_err", W'(bus.cnt_err), W'(0));
    chk("final_sfp_out", bus.sfp_out, W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 1 exp 0");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
